// File: rtl/multi_push_fifo.sv
// Multi-lane push FIFO: up to NUM_PUSH pushes per cycle, one show-ahead pop per cycle.
// Accepted lanes are compacted in lane order into consecutive slots. push_ready is
// registered and conservative: it is high only when a full-width push is guaranteed to fit.
module multi_push_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned NUM_PUSH    = 2,
  parameter int unsigned ALMOST_FULL = (1 << DEPTH_LOG2) - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PUSH-1:0]       push_valid,
  input  logic [NUM_PUSH*WIDTH-1:0] push_data,
  output logic                      push_ready,
  output logic                      pop_valid,
  output logic [WIDTH-1:0]          pop_data,
  input  logic                      pop_ready,
  output logic [DEPTH_LOG2:0]       count,
  output logic                      almost_full,
  output logic                      overflow_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = $clog2(NUM_PUSH + 1);
  // One extra bit so count + n_push never wraps before the overflow check.
  localparam int unsigned XW    = CW + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] front_q, front_d;
  logic [DEPTH_LOG2-1:0] back_q, back_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ready_q, push_ready_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_err_q, overflow_err_d;

  logic [PW-1:0]         n_push;
  logic [NUM_PUSH-1:0]   wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx [NUM_PUSH];
  logic                  pop_fire;
  logic [XW-1:0]         count_ext;

  // Lane compaction: each accepted lane lands at back + (accepted lanes below it).
  always_comb begin
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      wr_en[i]  = push_ready_q & push_valid[i];
      // acc stays below NUM_PUSH <= DEPTH here, so the truncation is lossless.
      wr_idx[i] = back_q + DEPTH_LOG2'(acc);
      if (wr_en[i]) begin
        acc = acc + PW'(1);
      end
    end
    n_push = acc;
  end

  // Next-state for pointers, occupancy and registered flags.
  always_comb begin
    pop_fire       = (count_q != '0) && pop_ready;
    count_ext      = XW'(count_q) + XW'(n_push) - XW'(pop_fire);
    count_d        = count_ext[CW-1:0];
    front_d        = front_q + DEPTH_LOG2'(pop_fire);
    back_d         = back_q + DEPTH_LOG2'(n_push);
    // Never credits a same-cycle pop: ready only if a full-width push fits next cycle.
    push_ready_d   = (XW'(DEPTH) - XW'(count_d)) >= XW'(NUM_PUSH);
    almost_full_d  = XW'(count_d) >= XW'(ALMOST_FULL);
    overflow_err_d = overflow_err_q
                   | ((|push_valid) & ~push_ready_q)
                   | (count_ext > XW'(DEPTH));
  end

  // Control state with asynchronous reset; contents are discarded by zeroing the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q        <= '0;
      back_q         <= '0;
      count_q        <= '0;
      push_ready_q   <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      front_q        <= front_d;
      back_q         <= back_d;
      count_q        <= count_d;
      push_ready_q   <= push_ready_d;
      almost_full_q  <= almost_full_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Storage write; entries need no reset since pop_valid gates their visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= push_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign push_ready   = push_ready_q;
  assign pop_valid    = (count_q != '0);
  assign pop_data     = mem_q[front_q];
  assign count        = count_q;
  assign almost_full  = almost_full_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_multi_push_fifo.sv
// Directed bench for multi_push_fifo: a table of single-cycle vectors plus
// hand-written sequences for reset, sparse lanes, wrap-around and the error flag.
module tb_multi_push_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH=4, NUM_PUSH=2, ALMOST_FULL=2.
  logic [1:0]  a_pv = '0;
  logic [15:0] a_pd = '0;
  logic        a_prdy_in = 1'b0;
  logic        a_push_ready, a_pop_valid, a_af, a_err;
  logic [7:0]  a_pop_data;
  logic [2:0]  a_count;

  multi_push_fifo #(
    .WIDTH(8), .DEPTH_LOG2(2), .NUM_PUSH(2), .ALMOST_FULL(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .push_valid(a_pv), .push_data(a_pd), .push_ready(a_push_ready),
    .pop_valid(a_pop_valid), .pop_data(a_pop_data), .pop_ready(a_prdy_in),
    .count(a_count), .almost_full(a_af), .overflow_err(a_err)
  );

  // Instance B: DEPTH=8, NUM_PUSH=3 (room for count=5 and three sparse lanes).
  logic [2:0]  b_pv = '0;
  logic [23:0] b_pd = '0;
  logic        b_prdy_in = 1'b0;
  logic        b_push_ready, b_pop_valid, b_af, b_err;
  logic [7:0]  b_pop_data;
  logic [3:0]  b_count;

  multi_push_fifo #(
    .WIDTH(8), .DEPTH_LOG2(3), .NUM_PUSH(3), .ALMOST_FULL(6)
  ) u_b (
    .clk(clk), .rst(rst),
    .push_valid(b_pv), .push_data(b_pd), .push_ready(b_push_ready),
    .pop_valid(b_pop_valid), .pop_data(b_pop_data), .pop_ready(b_prdy_in),
    .count(b_count), .almost_full(b_af), .overflow_err(b_err)
  );

  typedef struct {
    logic [1:0] pv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       pr;
    int         e_cnt;
    logic       e_val;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_af;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int    q[$];
    int    g;
    int    popped;
    int    nv;
    string nm;

    // Fill/flags/simultaneous push-pop/empty-pop walk on instance A.
    vecs[0] = '{2'b11, 8'h10, 8'h11, 1'b0, 2, 1'b1, 8'h10, 1'b1, 1'b1};
    vecs[1] = '{2'b11, 8'h12, 8'h13, 1'b0, 4, 1'b1, 8'h10, 1'b0, 1'b1};
    vecs[2] = '{2'b00, 8'h00, 8'h00, 1'b1, 3, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[3] = '{2'b00, 8'h00, 8'h00, 1'b1, 2, 1'b1, 8'h12, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 8'hEE, 8'h14, 1'b1, 2, 1'b1, 8'h13, 1'b1, 1'b1};
    vecs[5] = '{2'b00, 8'h00, 8'h00, 1'b1, 1, 1'b1, 8'h14, 1'b1, 1'b0};
    vecs[6] = '{2'b01, 8'h55, 8'h00, 1'b1, 1, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[7] = '{2'b00, 8'h00, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{2'b00, 8'h00, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};

    // Reset state while rst is held.
    step();
    chk("rst_count", a_count, 0);
    chk("rst_pop_valid", a_pop_valid, 0);
    chk("rst_push_ready", a_push_ready, 1);
    chk("rst_almost_full", a_af, 0);
    chk("rst_overflow", a_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      a_pv      = vecs[i].pv;
      a_pd      = {vecs[i].d1, vecs[i].d0};
      a_prdy_in = vecs[i].pr;
      step();
      chk($sformatf("vec%0d_count", i), a_count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_pop_valid", i), a_pop_valid, vecs[i].e_val);
      if (vecs[i].e_val) chk($sformatf("vec%0d_pop_data", i), a_pop_data, vecs[i].e_data);
      chk($sformatf("vec%0d_push_ready", i), a_push_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_almost_full", i), a_af, vecs[i].e_af);
      chk($sformatf("vec%0d_overflow", i), a_err, 0);
    end
    a_pv = '0;
    a_prdy_in = 1'b0;

    // Wrap-around: 20 push groups alternating 1 and 2 lanes, continuous pop.
    g = 0;
    popped = 0;
    nv = 8'h20;
    for (int c = 0; c < 300 && popped < 30; c++) begin
      a_prdy_in = 1'b1;
      if (a_pop_valid) begin
        if (q.size() == 0) begin
          chk("wrap_unexpected_pop", a_pop_data, 'hFFFF);
        end else begin
          chk("wrap_data", a_pop_data, q.pop_front());
        end
        popped++;
      end
      a_pv = '0;
      if (g < 20 && a_push_ready) begin
        if (g % 2 == 0) begin
          a_pv = 2'b01;
          a_pd = {8'h00, 8'(nv)};
          q.push_back(nv);
          nv++;
        end else begin
          a_pv = 2'b11;
          a_pd = {8'(nv + 1), 8'(nv)};
          q.push_back(nv);
          q.push_back(nv + 1);
          nv += 2;
        end
        g++;
      end
      step();
    end
    a_pv = '0;
    a_prdy_in = 1'b0;
    chk("wrap_popped", popped, 30);
    chk("wrap_groups", g, 20);
    chk("wrap_count", a_count, 0);
    chk("wrap_overflow", a_err, 0);

    // Protocol error: push while full is dropped and sets the sticky flag.
    a_pv = 2'b11; a_pd = {8'hA1, 8'hA0}; step();
    a_pv = 2'b11; a_pd = {8'hA3, 8'hA2}; step();
    a_pv = '0;
    chk("full_count", a_count, 4);
    chk("full_push_ready", a_push_ready, 0);
    a_pv = 2'b01; a_pd = {8'h00, 8'h77}; step();
    a_pv = '0;
    chk("err_count", a_count, 4);
    chk("err_flag", a_err, 1);
    repeat (10) step();
    chk("err_sticky", a_err, 1);
    for (int k = 0; k < 4; k++) begin
      a_prdy_in = 1'b1;
      nm = $sformatf("err_drain%0d", k);
      chk(nm, a_pop_data, 'hA0 + k);
      step();
    end
    a_prdy_in = 1'b0;
    chk("err_drain_empty", a_pop_valid, 0);
    chk("err_still_set", a_err, 1);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", a_err, 0);
    step();
    rst = 1'b0;

    // Asynchronous reset mid-stream with count=5 on instance B.
    b_pv = 3'b111; b_pd = {8'h03, 8'h02, 8'h01}; step();
    b_pv = 3'b011; b_pd = {8'h00, 8'h05, 8'h04}; step();
    b_pv = '0;
    chk("b_count5", b_count, 5);
    rst = 1'b1;
    #1;
    chk("async_rst_count", b_count, 0);
    chk("async_rst_pop_valid", b_pop_valid, 0);
    chk("async_rst_push_ready", b_push_ready, 1);
    chk("async_rst_overflow", b_err, 0);
    step();
    rst = 1'b0;

    // Sparse lanes: 3'b101 compacts lane 2 behind lane 0.
    b_pv = 3'b101; b_pd = {8'hC3, 8'hEE, 8'hA1}; b_prdy_in = 1'b0; step();
    b_pv = '0;
    chk("sparse_count", b_count, 2);
    chk("sparse_pop_valid", b_pop_valid, 1);
    chk("sparse_first", b_pop_data, 'hA1);
    b_prdy_in = 1'b1;
    step();
    chk("sparse_second", b_pop_data, 'hC3);
    chk("sparse_count1", b_count, 1);
    step();
    chk("sparse_empty", b_pop_valid, 0);
    b_prdy_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
